// File: rtl/cpu_io_bridge_pkg.sv
// cpu_io_bridge_pkg: shared bit indices for the CPU port I/O bridge.
// Command bits are carried on cpu_out2, and status bits are reported on cpu_in1.
// The package holds no logic and has no ports.
package cpu_io_bridge_pkg;

  typedef logic [7:0] byte_t;

  // cpu_out2 bit positions; each toggle of one of these bits is one event
  localparam int CMD_PUSH = 0;
  localparam int CMD_POP  = 1;
  localparam int CMD_CLR  = 2;

  // cpu_in1 bit positions
  localparam int ST_RXNE      = 0;
  localparam int ST_TXF       = 1;
  localparam int ST_TXE       = 2;
  localparam int ST_TXOVF     = 3;
  localparam int ST_RXUDF     = 4;
  localparam int ST_RXCNT_LSB = 5;
  localparam int ST_RXCNT_W   = 3;

endpackage

// File: rtl/cpu_io_bridge_fifo.sv
// byte_fifo: DEPTH-entry byte FIFO with a registered count. dout shows the head, or 0 when empty.
// Latency: a pushed byte becomes visible on dout the cycle after the push edge. There is no bypass.
// Backpressure: a push is ignored when full unless a pop happens in the same cycle. A pop is ignored when empty.
// Ports: clk, reset (sync, active-low), push/pop strobes, din, dout, full, empty, count.
module byte_fifo
  import cpu_io_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  byte_t         din,
  output byte_t         dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rd_q];

  // A push while full is legal only when the same edge frees the head slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // DEPTH is a power of two, so the pointers wrap naturally.
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // The storage array needs no reset. It is never visible while the count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: peripheral end of the CPU port I/O. It turns out1/out2 toggle commands into a TX byte stream,
// and it turns an RX byte stream into in1 status and in2 data.
// Latency: a command toggle acts on the edge after it is driven, and its result is visible one cycle later.
// Backpressure: TX waits for tx_ready. rx_ready drops when RX is full. TX overflow and RX underflow are sticky flags.
// Ports: cpu_out1 (TX byte) and cpu_out2 (cmd toggles) come from the CPU. cpu_in1 (status) and cpu_in2 (RX head) go to the CPU.
//        tx_data/tx_valid/tx_ready and rx_data/rx_valid/rx_ready form the device-side handshakes.
module cpu_io_bridge
  import cpu_io_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpu_out1,
  input  logic [7:0] cpu_out2,
  output logic [7:0] cpu_in1,
  output logic [7:0] cpu_in2,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  logic [2:0]  prev_cmd_q;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_udf_q, rx_udf_d;
  logic [2:0]  ev;

  logic        tx_full, tx_empty, tx_pop;
  logic        rx_full, rx_empty, rx_acc;
  logic [AW:0] tx_count_unused;
  logic [AW:0] rx_count;
  logic        unused_cmd_hi;

  // Only the low three command bits carry events. Changes on the upper bits are ignored.
  assign unused_cmd_hi = ^{cpu_out2[7:3], tx_count_unused};
  assign ev = cpu_out2[2:0] ^ prev_cmd_q;

  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = !rx_full;
  assign rx_acc   = rx_valid && rx_ready;

  byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev[CMD_PUSH]),
    .pop   (tx_pop),
    .din   (cpu_out1),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count_unused)
  );

  byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_acc),
    .pop   (ev[CMD_POP]),
    .din   (rx_data),
    .dout  (cpu_in2),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // If a flag is set and cleared on the same edge, the set wins.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (ev[CMD_CLR]) begin
      tx_ovf_d = 1'b0;
      rx_udf_d = 1'b0;
    end
    if (ev[CMD_PUSH] && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (ev[CMD_POP] && rx_empty)            rx_udf_d = 1'b1;
  end

  // prev_cmd tracks cpu_out2 during reset as well. This stops a level held across reset from firing an event on release.
  always_ff @(posedge clk) begin
    prev_cmd_q <= cpu_out2[2:0];
    if (!reset) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  always_comb begin
    cpu_in1 = '0;
    cpu_in1[ST_RXNE]  = !rx_empty;
    cpu_in1[ST_TXF]   = tx_full;
    cpu_in1[ST_TXE]   = tx_empty;
    cpu_in1[ST_TXOVF] = tx_ovf_q;
    cpu_in1[ST_RXUDF] = rx_udf_q;
    cpu_in1[ST_RXCNT_LSB +: ST_RXCNT_W] = ST_RXCNT_W'(rx_count);
  end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// tb_cpu_io_bridge: scoreboard bench for cpu_io_bridge.
// Latency: the expected state is updated at each negedge from the inputs that the next posedge will sample.
// Backpressure: tx_ready and rx_valid are driven directly from the stimulus.
module tb_cpu_io_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_out1, cpu_out2, cpu_in1, cpu_in2;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] tx_got[$];
  logic [7:0] rx_got[$];
  logic       ovf_m = 1'b0, udf_m = 1'b0;
  logic [2:0] prev_m = 3'b000;
  logic       live = 1'b0;

  always #5 clk = ~clk;

  cpu_io_bridge #(.DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_out1 (cpu_out1),
    .cpu_out2 (cpu_out2),
    .cpu_in1  (cpu_in1),
    .cpu_in2  (cpu_in2),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tgl(input int b);
    cpu_out2[b] = ~cpu_out2[b];
    tick(1);
  endtask

  // Monitor: this compares the outputs against the scoreboard, then advances the scoreboard with the pending inputs.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      txq.delete();
      rxq.delete();
      ovf_m  = 1'b0;
      udf_m  = 1'b0;
      prev_m = cpu_out2[2:0];
      live   = 1'b1;
    end else if (live) begin
      logic [7:0] e;
      logic [2:0] ev;
      int         nrx;
      bit         txp, rxp, rxa, tx_was_full;
      nrx     = rxq.size();
      e       = '0;
      e[0]    = (nrx != 0);
      e[1]    = (txq.size() == 4);
      e[2]    = (txq.size() == 0);
      e[3]    = ovf_m;
      e[4]    = udf_m;
      e[7:5]  = nrx[2:0];
      chk("status", cpu_in1, e);
      chk("tx_valid", tx_valid, txq.size() != 0);
      chk("tx_data", tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
      chk("rx_ready", rx_ready, nrx < 4);
      chk("cpu_in2", cpu_in2, (nrx != 0) ? rxq[0] : 8'h00);

      ev          = cpu_out2[2:0] ^ prev_m;
      prev_m      = cpu_out2[2:0];
      tx_was_full = (txq.size() == 4);
      txp         = (txq.size() != 0) && tx_ready;
      if (tx_valid && tx_ready) tx_got.push_back(tx_data);
      if (txp) void'(txq.pop_front());
      if (ev[0]) begin
        if (!tx_was_full || txp) txq.push_back(cpu_out1);
      end
      rxa = rx_valid && (nrx < 4);
      rxp = ev[1] && (nrx != 0);
      if (rxp) begin
        rx_got.push_back(cpu_in2);
        void'(rxq.pop_front());
      end
      if (rxa) rxq.push_back(rx_data);
      if (ev[2]) begin
        ovf_m = 1'b0;
        udf_m = 1'b0;
      end
      if (ev[0] && tx_was_full && !txp) ovf_m = 1'b1;
      if (ev[1] && nrx == 0)            udf_m = 1'b1;
    end
  end

  initial begin
    reset    = 1'b0;
    cpu_out1 = 8'h00;
    cpu_out2 = 8'h07;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(3);
    reset = 1'b1;
    tick(2);
    chk("reset_in1", cpu_in1, 8'h04);
    chk("reset_txv", tx_valid, 1'b0);
    chk("reset_rxr", rx_ready, 1'b1);
    chk("reset_in2", cpu_in2, 8'h00);

    // single byte that passes straight through
    tx_ready = 1'b1;
    cpu_out1 = 8'hA5;
    tgl(0);
    chk("tx1_valid", tx_valid, 1'b1);
    chk("tx1_data", tx_data, 8'hA5);
    tick(1);
    chk("tx1_gone", tx_valid, 1'b0);
    chk("tx1_empty", cpu_in1[2], 1'b1);

    // overflow, followed by an in-order drain
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cpu_out1 = 8'(i);
      tgl(0);
      if (i == 4) chk("tx_full", cpu_in1[1], 1'b1);
    end
    chk("tx_ovf", cpu_in1[3], 1'b1);
    tx_got.delete();
    tx_ready = 1'b1;
    tick(6);
    tx_ready = 1'b0;
    chk("drain_n", tx_got.size(), 4);
    for (int i = 0; i < 4 && i < tx_got.size(); i++) chk("drain_byte", tx_got[i], 8'(i + 1));
    tgl(2);
    chk("ovf_clr", cpu_in1[3], 1'b0);

    // RX receive followed by a CPU pop
    rx_valid = 1'b1;
    rx_data = 8'h11; tick(1);
    rx_data = 8'h22; tick(1);
    rx_data = 8'h33; tick(1);
    rx_valid = 1'b0;
    chk("rx_cnt3", cpu_in1[7:5], 3'd3);
    chk("rx_head11", cpu_in2, 8'h11);
    tgl(1);
    chk("rx_head22", cpu_in2, 8'h22);
    chk("rx_cnt2", cpu_in1[7:5], 3'd2);

    // fill to full, hold a byte, then pop and accept on the same edge
    rx_valid = 1'b1;
    rx_data = 8'h44; tick(1);
    rx_data = 8'h55; tick(1);
    chk("rx_full_rdy", rx_ready, 1'b0);
    rx_data = 8'h66; tick(2);
    chk("rx_cnt4", cpu_in1[7:5], 3'd4);
    tgl(1);                       // 4 -> 3, 66 still held
    tgl(1);                       // pop 33 and accept 66 together
    chk("rx_pop_acc_cnt", cpu_in1[7:5], 3'd3);
    rx_data = 8'h77; tick(1);
    rx_valid = 1'b0;
    chk("rx_cnt4b", cpu_in1[7:5], 3'd4);
    rx_got.delete();
    repeat (4) tgl(1);
    chk("rx_drain_n", rx_got.size(), 4);
    if (rx_got.size() == 4) begin
      chk("rx_o0", rx_got[0], 8'h44);
      chk("rx_o1", rx_got[1], 8'h55);
      chk("rx_o2", rx_got[2], 8'h66);
      chk("rx_o3", rx_got[3], 8'h77);
    end

    // underflow, clear, and clear issued together with an underflow
    tgl(1);
    chk("rx_udf", cpu_in1[4], 1'b1);
    tgl(2);
    chk("udf_clr", cpu_in1[4], 1'b0);
    cpu_out2 = cpu_out2 ^ 8'h06;
    tick(1);
    chk("udf_set_wins", cpu_in1[4], 1'b1);
    tgl(2);

    // reset asserted mid-transfer
    tx_ready = 1'b0;
    cpu_out1 = 8'hC3; tgl(0);
    cpu_out1 = 8'h3C; tgl(0);
    reset = 1'b0;
    tick(1);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_in1", cpu_in1, 8'h04);
    reset = 1'b1;
    tick(1);

    // random traffic, including toggles on the ignored high command bits
    repeat (400) begin
      cpu_out2 = 8'($urandom);
      cpu_out1 = 8'($urandom);
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      tick(1);
    end
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
